// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder definitions: IDCT cosine constants, default lane widths
// and helpers for packed-lane vector and accumulator widths.
package jpeg_dec_pkg;

    localparam int C1 = 63;
    localparam int C2 = 59;
    localparam int C3 = 53;
    localparam int C4 = 45;
    localparam int C5 = 36;
    localparam int C6 = 24;
    localparam int C7 = 12;

    localparam int IDCT_IN_W  = 12;
    localparam int IDCT_OUT_W = 9;
    localparam int IDCT_SHIFT = 7;

    // Eight lanes are packed side by side with lane 0 in the MSBs.
    function automatic int lane_vec_w(input int lane_w);
        return 8 * lane_w;
    endfunction

    function automatic int idct_acc_w(input int in_w);
        return in_w + 10;
    endfunction

endpackage

// File: rtl/idct_1d_pipe_if.sv
// Valid/ready stream bundle carrying one 8-lane coefficient vector in and
// one 8-lane sample vector out.
interface idct_1d_pipe_if
    import jpeg_dec_pkg::*;
#(
    parameter int IN_W  = IDCT_IN_W,
    parameter int OUT_W = IDCT_OUT_W
);
    logic [lane_vec_w(IN_W)-1:0]  in;
    logic                         in_valid;
    logic                         in_ready;
    logic [lane_vec_w(OUT_W)-1:0] out;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_sat;
    logic                         out_last;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_sat, out_last
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_sat, out_last
    );
endinterface

// File: rtl/idct_round_sat.sv
// One output lane: scale the accumulator down by 2^SHIFT rounding half away
// from zero, then clip to the signed OUT_W range and flag any clipping.
module idct_round_sat #(
    parameter int ACC_W = 22,
    parameter int OUT_W = 9,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

    logic signed [RW-1:0] neg;
    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] q;

    // Subtracting one for negative values turns the flooring shift into
    // round-half-away-from-zero for both signs.
    always_comb begin
        neg    = {{(RW - 1){1'b0}}, acc[ACC_W-1]};
        biased = RW'(acc) + HALF - neg;
        q      = biased >>> SHIFT;
        sat    = 1'b0;
        y      = q[OUT_W-1:0];
        if (q > MAXV) begin
            y   = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (q < MINV) begin
            y   = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/idct_1d_pipe.sv
// Three-stage 8-point 1-D IDCT: products, butterflies, round/saturate.
// The whole pipe stalls together when the output is held by the consumer.
module idct_1d_pipe
    import jpeg_dec_pkg::*;
#(
    parameter int IN_W  = IDCT_IN_W,
    parameter int OUT_W = IDCT_OUT_W,
    parameter int SHIFT = IDCT_SHIFT
) (
    input logic           clk,
    input logic           rst,
    idct_1d_pipe_if.slave bus
);
    localparam int ACC_W = idct_acc_w(IN_W);
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t K1 = acc_t'(C1);
    localparam acc_t K2 = acc_t'(C2);
    localparam acc_t K3 = acc_t'(C3);
    localparam acc_t K4 = acc_t'(C4);
    localparam acc_t K5 = acc_t'(C5);
    localparam acc_t K6 = acc_t'(C6);
    localparam acc_t K7 = acc_t'(C7);
    localparam acc_t KO [4] = '{K1, K3, K5, K7};

    logic                         advance;
    logic                         s1_valid, s2_valid, s3_valid;
    acc_t                         x [8];
    acc_t                         s1_even [6];
    acc_t                         s1_odd [4][4];
    acc_t                         e [4];
    acc_t                         o [4];
    acc_t                         s2_acc [8];
    logic signed [OUT_W-1:0]      rs_y [8];
    logic [7:0]                   rs_sat;
    logic [lane_vec_w(OUT_W)-1:0] s3_next;
    logic [lane_vec_w(OUT_W)-1:0] s3_data;
    logic                         s3_sat;
    logic [2:0]                   out_cnt;

    assign advance      = !(s3_valid && !bus.out_ready);
    assign bus.in_ready = advance;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            x[i] = acc_t'($signed(bus.in[(7 - i) * IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_sat   <= 1'b0;
            out_cnt  <= 3'd0;
        end else begin
            if (advance) begin
                s1_valid <= bus.in_valid;
                s2_valid <= s1_valid;
                s3_valid <= s2_valid;
                s3_sat   <= |rs_sat;
            end
            if (s3_valid && bus.out_ready) begin
                out_cnt <= out_cnt + 3'd1;
            end
        end
    end

    // s1_odd[j][k] holds KO[k] times odd input X(2j+1).
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_even[0] <= K4 * (x[0] + x[4]);
            s1_even[1] <= K4 * (x[0] - x[4]);
            s1_even[2] <= K2 * x[2];
            s1_even[3] <= K6 * x[2];
            s1_even[4] <= K2 * x[6];
            s1_even[5] <= K6 * x[6];
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) begin
                    s1_odd[j][k] <= KO[k] * x[2 * j + 1];
                end
            end
        end
    end

    always_comb begin
        e[0] = s1_even[0] + s1_even[2] + s1_even[5];
        e[1] = s1_even[1] + s1_even[3] - s1_even[4];
        e[2] = s1_even[1] - s1_even[3] + s1_even[4];
        e[3] = s1_even[0] - s1_even[2] - s1_even[5];
        o[0] = s1_odd[0][0] + s1_odd[1][1] + s1_odd[2][2] + s1_odd[3][3];
        o[1] = s1_odd[0][1] - s1_odd[1][3] - s1_odd[2][0] - s1_odd[3][2];
        o[2] = s1_odd[0][2] - s1_odd[1][0] + s1_odd[2][3] + s1_odd[3][1];
        o[3] = s1_odd[0][3] - s1_odd[1][2] + s1_odd[2][1] - s1_odd[3][0];
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int n = 0; n < 4; n++) begin
                s2_acc[n]     <= e[n] + o[n];
                s2_acc[7 - n] <= e[n] - o[n];
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        idct_round_sat #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_round_sat (
            .acc (s2_acc[g]),
            .y   (rs_y[g]),
            .sat (rs_sat[g])
        );
    end

    always_comb begin
        s3_next = '0;
        for (int i = 0; i < 8; i++) begin
            s3_next[(7 - i) * OUT_W +: OUT_W] = rs_y[i];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s3_data <= s3_next;
        end
    end

    assign bus.out       = s3_valid ? s3_data : '0;
    assign bus.out_valid = s3_valid;
    assign bus.out_sat   = s3_valid && s3_sat;
    assign bus.out_last  = s3_valid && (out_cnt == 3'd7);
endmodule

// File: tb/tb_idct_1d_pipe.sv
// Directed bench for idct_1d_pipe: single-lane basis vectors with hand-computed
// samples, saturation, random backpressure and a mid-flight reset.
module tb_idct_1d_pipe;
    localparam int IN_W  = 12;
    localparam int OUT_W = 9;
    localparam int NVEC  = 17;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   delivered;

    idct_1d_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    idct_1d_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each stimulus vector has a single non-zero coefficient.
    int hot_lane [NVEC] = '{0, 1, 0, 0, 0, 2, 3, 4, 5, 6, 7, 1, 0, 0, 0, 0, 0};
    int hot_val  [NVEC] = '{64, 64, -64, 2047, -2048, 64, 64, 64, 64, 64, 64,
                            -64, 128, 100, -100, 300, 1000};
    int exp_lanes [NVEC][8] = '{
        '{ 23,  23,  23,  23,  23,  23,  23,  23},
        '{ 32,  27,  18,   6,  -6, -18, -27, -32},
        '{-23, -23, -23, -23, -23, -23, -23, -23},
        '{255, 255, 255, 255, 255, 255, 255, 255},
        '{-256, -256, -256, -256, -256, -256, -256, -256},
        '{ 30,  12, -12, -30, -30, -12,  12,  30},
        '{ 27,  -6, -32, -18,  18,  32,   6, -27},
        '{ 23, -23, -23,  23,  23, -23, -23,  23},
        '{ 18, -32,   6,  27, -27,  -6,  32, -18},
        '{ 12, -30,  30, -12, -12,  30, -30,  12},
        '{  6, -18,  27, -32,  32, -27,  18,  -6},
        '{-32, -27, -18,  -6,   6,  18,  27,  32},
        '{ 45,  45,  45,  45,  45,  45,  45,  45},
        '{ 35,  35,  35,  35,  35,  35,  35,  35},
        '{-35, -35, -35, -35, -35, -35, -35, -35},
        '{105, 105, 105, 105, 105, 105, 105, 105},
        '{255, 255, 255, 255, 255, 255, 255, 255}
    };
    bit exp_sat [NVEC] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    logic [8*IN_W-1:0]  in_tab  [NVEC];
    logic [8*OUT_W-1:0] exp_tab [NVEC];

    task automatic checkOutput(input string tag, input logic [95:0] actual,
                               input logic [95:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        delivered = 0;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", bus.in_ready, 1'b1);
    endtask

    // Streams table entries first..first+count-1 and checks each delivery,
    // output stability under stall and the handshake-derived in_ready.
    task automatic applyStimulus(input int first, input int count, input bit rnd,
                                 input int budget);
        int sent = 0;
        int got = 0;
        int acc_cyc = 0;
        bit held = 1'b0;
        logic [8*OUT_W-1:0] held_out = '0;
        logic held_sat = 1'b0;
        logic held_last = 1'b0;
        for (int cyc = 0; cyc < budget && got < count; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < count);
            bus.in        = (sent < count) ? in_tab[first + sent] : '0;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            checkOutput("in_ready rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (held) begin
                checkOutput("stall out", bus.out, held_out);
                checkOutput("stall sat", bus.out_sat, held_sat);
                checkOutput("stall last", bus.out_last, held_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                checkOutput($sformatf("data vec %0d", first + got), bus.out, exp_tab[first + got]);
                checkOutput($sformatf("sat vec %0d", first + got), bus.out_sat, exp_sat[first + got]);
                checkOutput($sformatf("last out %0d", delivered), bus.out_last, (delivered % 8) == 7);
                if (count == 1) begin
                    checkOutput("latency", cyc - acc_cyc, 3);
                end
                got++;
                delivered++;
            end
            held      = bus.out_valid && !bus.out_ready;
            held_out  = bus.out;
            held_sat  = bus.out_sat;
            held_last = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc = cyc;
                sent++;
            end
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        checkOutput($sformatf("delivered from %0d", first), got, count);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stale;
        for (int k = 0; k < NVEC; k++) begin
            in_tab[k]  = '0;
            exp_tab[k] = '0;
            in_tab[k][(7 - hot_lane[k]) * IN_W +: IN_W] = IN_W'(hot_val[k]);
            for (int i = 0; i < 8; i++) begin
                exp_tab[k][(7 - i) * OUT_W +: OUT_W] = OUT_W'(exp_lanes[k][i]);
            end
        end

        rst           = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests         = 0;
        fails         = 0;
        delivered     = 0;

        #3;
        checkOutput("reset out_valid", bus.out_valid, 1'b0);
        checkOutput("reset out_sat", bus.out_sat, 1'b0);
        checkOutput("reset out_last", bus.out_last, 1'b0);
        checkOutput("reset out", bus.out, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", bus.in_ready, 1'b1);

        applyStimulus(0, 1, 1'b0, 20);
        applyStimulus(1, 1, 1'b0, 20);
        applyStimulus(2, 1, 1'b0, 20);
        applyStimulus(3, 1, 1'b0, 20);
        applyStimulus(4, 1, 1'b0, 20);

        applyReset();
        applyStimulus(5, 12, 1'b1, 400);

        // Two vectors in flight, the first (saturating) parked at the output.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = in_tab[3];
        @(negedge clk);
        bus.in        = in_tab[1];
        @(negedge clk);
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("pre-reset out_valid", bus.out_valid, 1'b1);
        checkOutput("pre-reset out_sat", bus.out_sat, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", bus.out_valid, 1'b0);
        checkOutput("async reset out_sat", bus.out_sat, 1'b0);
        checkOutput("async reset out", bus.out, '0);
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        delivered     = 0;
        bus.out_ready = 1'b1;
        stale         = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checkOutput("stale outputs after reset", stale, 0);
        applyStimulus(5, 8, 1'b0, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/idct_1d_pipe.md
IDCT_1D_PIPE -- requirements
Module: idct_1d_pipe

Interface
REQ-001 Parameter IN_W, default 12, signed coefficient width per input lane.
REQ-002 Parameter OUT_W, default 9, signed sample width per output lane.
REQ-003 Parameter SHIFT, default 7, right-shift applied to each accumulator before rounding.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in  in  8*IN_W  coefficients X0..X7, with X0 in the MSBs, each lane signed.
REQ-008 in_valid  in  1  "in" holds a valid vector.
REQ-009 in_ready  out  1  the block accepts "in" this cycle.
REQ-010 out  out  8*OUT_W  samples x0..x7, with x0 in the MSBs, each lane signed.
REQ-011 out_valid  out  1  "out" holds a valid vector.
REQ-012 out_ready  in  1  the consumer accepts "out" this cycle.
REQ-013 out_sat  out  1  at least one lane of the current output vector was clipped.
REQ-014 out_last  out  1  the current output is the 8th vector of a block.

Function
REQ-015 Transfer rule: a vector is accepted when in_valid and in_ready are both 1; it is delivered when out_valid and out_ready are both 1.
REQ-016 Constants: C1=63, C2=59, C3=53, C4=45, C5=36, C6=24, C7=12.
REQ-017 Even terms:
- e0 = C4(X0+X4) + C2X2 + C6X6
- e1 = C4(X0-X4) + C6X2 - C2X6
- e2 = C4(X0-X4) - C6X2 + C2X6
- e3 = C4(X0+X4) - C2X2 - C6X6
REQ-018 Odd terms:
- o0 = C1X1 + C3X3 + C5X5 + C7X7
- o1 = C3X1 - C7X3 - C1X5 - C5X7
- o2 = C5X1 - C1X3 + C7X5 + C3X7
- o3 = C7X1 - C5X3 + C3X5 - C1X7
REQ-019 Outputs: acc_n = e_n + o_n and acc_(7-n) = e_n - o_n, for n = 0..3; all eight lanes are computed.
REQ-020 Accumulator width: IN_W+10 bits signed; no intermediate overflow is permitted.
REQ-021 Rounding: each lane = acc / 2^SHIFT, rounded half away from zero.
REQ-022 Saturation: each rounded value is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat is the OR of the per-lane clip flags.
REQ-023 Pipeline: three stages.
- S1 registers the pre-adds and products.
- S2 registers the butterflies.
- S3 registers the round/saturate result.
REQ-024 Latency: with out_ready held at 1, out_valid rises exactly 3 cycles after the accepting edge.
REQ-025 Throughput: one vector per cycle.
REQ-026 Stall: the pipeline stalls as a whole when S3 is valid and out_ready=0.
- in_ready = !(S3 valid && !out_ready).
- While stalled, every stage register holds its value.
REQ-027 Output stability: while out_valid=1 and out_ready=0, out, out_sat and out_last remain stable.
REQ-028 Bubbles: invalid stages propagate as bubbles and never set out_valid.
REQ-029 Vector counter: a 3-bit counter increments on each output handshake and wraps from 7 to 0.
- out_last = out_valid when the counter equals 7.
REQ-030 Simultaneous events: an accept and a delivery in the same cycle are both honoured with no loss or duplication.

Reset
REQ-031 On rst, all stage valid bits, the vector counter, out_valid, out_sat and out_last SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-032 Datapath registers are not required to reset, and out SHALL read 0 while out_valid=0.
REQ-033 A reset asserted mid-operation discards all in-flight vectors, and no partial output is emitted.
REQ-034 in_ready SHALL be 1 from the first clock edge after rst deasserts.

Structure
REQ-035 C1..C7, the default widths and the lane pack/unpack width functions SHALL live in the shared package jpeg_dec_pkg, shared with the other decoder blocks.
REQ-036 The per-lane round/saturate logic SHALL be one sub-module, idct_round_sat, instantiated 8 times in S3.

Verification
REQ-037 DC test: X0=64, all others 0, out_ready=1 -> all eight lanes = 23, out_sat=0, out_valid 3 cycles after acceptance.
REQ-038 Odd test: X1=64, all others 0 -> lanes x0..x7 = 32, 27, 18, 6, -6, -18, -27, -32.
REQ-039 Sign test: X0=-64, all others 0 -> all eight lanes = -23.
REQ-040 Saturation test: X0=2047, all others 0 -> all eight lanes = 255 and out_sat=1; with X0=-2048 -> all lanes = -256.
REQ-041 Backpressure test: 12 back-to-back vectors with out_ready toggling randomly -> all 12 delivered in order, output stable while stalled, out_last on the 8th output only.
REQ-042 Reset test: rst pulsed with 2 vectors in flight -> out_valid drops immediately, no stale vector after release, and the counter restarts so the next out_last falls on the 8th post-reset output.
